// File: rtl/fifo_param_sync_if.sv
// Push/pop handshake bundle between producer/consumer logic and fifo_param_sync.
// The FIFO side uses the slave modport; the driving side uses master.
interface fifo_param_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic                  clear;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  push_err_on_full;
  logic                  pop_err_on_empty;

  modport master (
    output clear, push, data_in, pop,
    input  data_out, full, empty, almost_full, almost_empty, count,
           push_err_on_full, pop_err_on_empty
  );

  modport slave (
    input  clear, push, data_in, pop,
    output data_out, full, empty, almost_full, almost_empty, count,
           push_err_on_full, pop_err_on_empty
  );
endinterface

// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, flush and
// selectable registered or first-word-fall-through read.
module fifo_param_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input logic               clk,
  input logic               rst,
  fifo_param_sync_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  push_err_q, push_err_d;
  logic                  pop_err_q, pop_err_d;
  logic                  full, empty, push_ok, pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A flush swallows any request in the same cycle, so neither is accepted.
  assign pop_ok  = bus.pop & ~empty & ~bus.clear;
  assign push_ok = bus.push & (~full | pop_ok) & ~bus.clear;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    push_err_d = bus.push & ~push_ok & ~bus.clear;
    pop_err_d  = bus.pop & ~pop_ok & ~bus.clear;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end else begin
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (FWFT == 0 && pop_ok) dout_d = mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      push_err_q <= push_err_d;
      pop_err_q  <= pop_err_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out         = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr_q]) : dout_q;
  assign bus.full             = full;
  assign bus.empty            = empty;
  assign bus.almost_full      = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty     = (count_q <= CW'(AE_LEVEL));
  assign bus.count            = count_q;
  assign bus.push_err_on_full = push_err_q;
  assign bus.pop_err_on_empty = pop_err_q;
endmodule

// File: tb/tb_fifo_param_sync.sv
// Bench for fifo_param_sync: a DEPTH=16 registered-read instance and a DEPTH=5
// FWFT instance, both compared every cycle against queue-based reference models.
module tb_fifo_param_sync;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fifo_param_sync_if #(.DATA_WIDTH(8), .DEPTH(16)) bus_a ();
  fifo_param_sync_if #(.DATA_WIDTH(8), .DEPTH(5))  bus_b ();

  fifo_param_sync #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fifo_param_sync #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ea_dout;
  logic       ea_werr, ea_rerr, eb_werr, eb_rerr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("a_count", 32'(bus_a.count), 32'(qa.size()));
    check_eq("a_full", 32'(bus_a.full), 32'(qa.size() == 16));
    check_eq("a_empty", 32'(bus_a.empty), 32'(qa.size() == 0));
    check_eq("a_afull", 32'(bus_a.almost_full), 32'(qa.size() >= 12));
    check_eq("a_aempty", 32'(bus_a.almost_empty), 32'(qa.size() <= 4));
    check_eq("a_dout", 32'(bus_a.data_out), 32'(ea_dout));
    check_eq("a_push_err", 32'(bus_a.push_err_on_full), 32'(ea_werr));
    check_eq("a_pop_err", 32'(bus_a.pop_err_on_empty), 32'(ea_rerr));
    check_eq("b_count", 32'(bus_b.count), 32'(qb.size()));
    check_eq("b_full", 32'(bus_b.full), 32'(qb.size() == 5));
    check_eq("b_empty", 32'(bus_b.empty), 32'(qb.size() == 0));
    check_eq("b_afull", 32'(bus_b.almost_full), 32'(qb.size() >= 4));
    check_eq("b_aempty", 32'(bus_b.almost_empty), 32'(qb.size() <= 1));
    check_eq("b_dout", 32'(bus_b.data_out), (qb.size() > 0) ? 32'(qb[0]) : 32'd0);
    check_eq("b_push_err", 32'(bus_b.push_err_on_full), 32'(eb_werr));
    check_eq("b_pop_err", 32'(bus_b.pop_err_on_empty), 32'(eb_rerr));
  endtask

  // One clock: update both models from the inputs seen at the edge, then compare.
  task automatic tick();
    bit pok, wok;
    @(posedge clk);
    if (!rst || bus_a.clear) begin
      qa.delete(); ea_dout = 8'h00; ea_werr = 1'b0; ea_rerr = 1'b0;
    end else begin
      pok = bus_a.pop && qa.size() > 0;
      wok = bus_a.push && (qa.size() < 16 || pok);
      ea_werr = bus_a.push && !wok;
      ea_rerr = bus_a.pop && !pok;
      if (pok) ea_dout = qa.pop_front();
      if (wok) qa.push_back(bus_a.data_in);
    end
    if (!rst || bus_b.clear) begin
      qb.delete(); eb_werr = 1'b0; eb_rerr = 1'b0;
    end else begin
      pok = bus_b.pop && qb.size() > 0;
      wok = bus_b.push && (qb.size() < 5 || pok);
      eb_werr = bus_b.push && !wok;
      eb_rerr = bus_b.pop && !pok;
      if (pok) void'(qb.pop_front());
      if (wok) qb.push_back(bus_b.data_in);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    bus_a.clear = 1'b0; bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.data_in = 8'h00;
    bus_b.clear = 1'b0; bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.data_in = 8'h00;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    ea_dout = 8'h00; ea_werr = 1'b0; ea_rerr = 1'b0; eb_werr = 1'b0; eb_rerr = 1'b0;
    @(negedge clk);

    // Reset held two cycles while pushing.
    bus_a.push = 1'b1; bus_a.data_in = 8'h11;
    bus_b.push = 1'b1; bus_b.data_in = 8'h22;
    tick(); tick();
    rst = 1'b1;
    idle();
    tick();

    // Fill A, overflow attempts, then push+pop while full.
    for (int i = 0; i < 16; i++) begin
      bus_a.push = 1'b1; bus_a.data_in = 8'(i); tick();
    end
    bus_a.data_in = 8'hEE; tick(); tick();
    idle(); tick();
    bus_a.push = 1'b1; bus_a.data_in = 8'hAA; bus_a.pop = 1'b1; tick();
    idle();
    for (int i = 0; i < 16; i++) begin
      bus_a.pop = 1'b1; tick();
    end
    tick(); tick();
    idle(); tick();

    // Push+pop on empty, then flush at count 7 with a push present.
    bus_a.push = 1'b1; bus_a.pop = 1'b1; bus_a.data_in = 8'h33; tick();
    idle(); bus_a.pop = 1'b1; tick();
    idle();
    for (int i = 0; i < 7; i++) begin
      bus_a.push = 1'b1; bus_a.data_in = 8'(8'h40 + i); tick();
    end
    bus_a.clear = 1'b1; tick();
    idle(); tick();
    bus_a.push = 1'b1; bus_a.data_in = 8'h55; tick();
    idle(); bus_a.pop = 1'b1; tick();
    idle(); tick();

    // B: interleaved traffic with occupancy kept in 2..4, across several wraps.
    for (int i = 0; i < 3; i++) begin
      bus_b.push = 1'b1; bus_b.data_in = 8'($urandom); tick();
    end
    for (int i = 0; i < 40; i++) begin
      bit pu, po;
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      if (qb.size() <= 2 && po && !pu) pu = 1'b1;
      if (qb.size() >= 4 && pu && !po) po = 1'b1;
      bus_b.push = pu; bus_b.pop = po; bus_b.data_in = 8'($urandom);
      tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      bus_b.pop = 1'b1; tick();
    end
    idle(); bus_b.push = 1'b1; bus_b.data_in = 8'h9C; tick();
    idle(); tick();
    bus_b.pop = 1'b1; tick();
    idle(); tick();

    // Random traffic on both, with occasional flush and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      bus_a.push = ($urandom_range(0, 99) < 55);
      bus_a.pop = ($urandom_range(0, 99) < 45);
      bus_a.clear = ($urandom_range(0, 99) < 3);
      bus_a.data_in = 8'($urandom);
      bus_b.push = ($urandom_range(0, 99) < 50);
      bus_b.pop = ($urandom_range(0, 99) < 50);
      bus_b.clear = ($urandom_range(0, 99) < 3);
      bus_b.data_in = 8'($urandom);
      rst = (i != 200);
      tick();
    end
    rst = 1'b1;
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
